// File: rtl/fetch_issue_buffer_if.sv
// Fetch/decode handshake bundle for the fetch-issue instruction buffer.
// The master modport is the fetch and decode side; the slave modport is the buffer.
interface fetch_issue_buffer_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
);
  logic                     flush;
  logic                     fetch_valid;
  logic                     fetch_inst1_valid;
  logic [XLEN-1:0]          fetch_pc;
  logic [XLEN-1:0]          fetch_inst0;
  logic [XLEN-1:0]          fetch_inst1;
  logic                     fetch_ready;
  logic                     slotA_valid;
  logic [XLEN-1:0]          slotA_pc;
  logic [XLEN-1:0]          slotA_inst;
  logic                     slotB_valid;
  logic [XLEN-1:0]          slotB_pc;
  logic [XLEN-1:0]          slotB_inst;
  logic [1:0]               issue_count;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    output flush, fetch_valid, fetch_inst1_valid, fetch_pc, fetch_inst0, fetch_inst1, issue_count,
    input  fetch_ready, slotA_valid, slotA_pc, slotA_inst, slotB_valid, slotB_pc, slotB_inst, occupancy
  );

  modport slave (
    input  flush, fetch_valid, fetch_inst1_valid, fetch_pc, fetch_inst0, fetch_inst1, issue_count,
    output fetch_ready, slotA_valid, slotA_pc, slotA_inst, slotB_valid, slotB_pc, slotB_inst, occupancy
  );
endinterface

// File: rtl/fetch_issue_buffer.sv
// Circular instruction buffer between a 2-wide fetch and a 0/1/2-wide decode.
// Optional macro FIB_STATS_EN adds saturating stall/empty/split statistics counters.
module fetch_issue_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                 half_clock,
  input  logic                 reset,
`ifdef FIB_STATS_EN
  output logic [31:0]          stat_stall_cycles,
  output logic [31:0]          stat_empty_cycles,
  output logic [31:0]          stat_split_issues,
`endif
  fetch_issue_buffer_if.slave  fib
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] r_pc   [DEPTH];
  logic [XLEN-1:0] r_inst [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_ready;
  logic            w_push;
  logic [1:0]      w_push_n;
  logic [1:0]      w_avail;
  logic [1:0]      w_req;
  logic [1:0]      w_pop_n;
  logic [AW-1:0]   w_wr_ptr1;
  logic [AW-1:0]   w_rd_ptr1;

  // Readiness looks only at the registered count so fetch never depends on decode.
  assign w_ready   = (r_count <= CW'(DEPTH - 2));
  assign w_push    = fib.fetch_valid && w_ready && !fib.flush;
  assign w_push_n  = w_push ? (fib.fetch_inst1_valid ? 2'd2 : 2'd1) : 2'd0;
  assign w_avail   = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];
  assign w_req     = (fib.issue_count == 2'd3) ? 2'd2 : fib.issue_count;
  assign w_pop_n   = (w_req < w_avail) ? w_req : w_avail;
  assign w_wr_ptr1 = r_wr_ptr + PTR_ONE;
  assign w_rd_ptr1 = r_rd_ptr + PTR_ONE;

  always_ff @(posedge half_clock) begin
    if (w_push) begin
      r_pc[r_wr_ptr]   <= fib.fetch_pc;
      r_inst[r_wr_ptr] <= fib.fetch_inst0;
      if (fib.fetch_inst1_valid) begin
        r_pc[w_wr_ptr1]   <= fib.fetch_pc + XLEN'(4);
        r_inst[w_wr_ptr1] <= fib.fetch_inst1;
      end
    end
  end

  always_ff @(posedge half_clock) begin
    if (!reset || fib.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(w_pop_n);
      r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
      r_count  <= r_count + CW'(w_push_n) - CW'(w_pop_n);
    end
  end

  always_comb begin
    fib.fetch_ready = w_ready;
    fib.occupancy   = r_count;
    fib.slotA_valid = (r_count >= CW'(1));
    fib.slotB_valid = (r_count >= CW'(2));
    fib.slotA_pc    = '0;
    fib.slotA_inst  = NOP;
    fib.slotB_pc    = '0;
    fib.slotB_inst  = NOP;
    if (fib.slotA_valid) begin
      fib.slotA_pc   = r_pc[r_rd_ptr];
      fib.slotA_inst = r_inst[r_rd_ptr];
    end
    if (fib.slotB_valid) begin
      fib.slotB_pc   = r_pc[w_rd_ptr1];
      fib.slotB_inst = r_inst[w_rd_ptr1];
    end
  end

`ifdef FIB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge half_clock) begin
    if (!reset) begin
      stat_stall_cycles <= '0;
      stat_empty_cycles <= '0;
      stat_split_issues <= '0;
    end else begin
      if (fib.fetch_valid && !w_ready)
        stat_stall_cycles <= sat_inc(stat_stall_cycles);
      if (r_count == '0)
        stat_empty_cycles <= sat_inc(stat_empty_cycles);
      if (fib.slotB_valid && fib.issue_count == 2'd1)
        stat_split_issues <= sat_inc(stat_split_issues);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_issue_buffer.sv
// Scoreboard bench for fetch_issue_buffer: a queue-based reference model predicts each cycle's outputs.
module tb_fetch_issue_buffer;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic half_clock = 1'b0;
  logic reset = 1'b0;
  always #5 half_clock = ~half_clock;

  fetch_issue_buffer_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

`ifdef FIB_STATS_EN
  logic [31:0] stat_stall_cycles, stat_empty_cycles, stat_split_issues;
  fetch_issue_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .half_clock(half_clock), .reset(reset),
    .stat_stall_cycles(stat_stall_cycles), .stat_empty_cycles(stat_empty_cycles),
    .stat_split_issues(stat_split_issues), .fib(bus.slave));
`else
  fetch_issue_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .half_clock(half_clock), .reset(reset), .fib(bus.slave));
`endif

  typedef struct {
    logic        av;
    logic [31:0] apc;
    logic [31:0] ainst;
    logic        bv;
    logic [31:0] bpc;
    logic [31:0] binst;
    logic [31:0] occ;
    logic        rdy;
  } snap_t;

  snap_t       exp_q[$];
  logic [63:0] mq[$];
  int checks = 0;
  int failures = 0;
  bit done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle at the falling edge and predict the state after the next rising edge.
  task automatic step(input logic rst_n, input logic fl, input logic fv, input logic i1v,
                      input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] ic);
    int req, avail, np;
    bit rdy;
    snap_t s;
    @(negedge half_clock);
    reset = rst_n;
    bus.flush = fl;
    bus.fetch_valid = fv;
    bus.fetch_inst1_valid = i1v;
    bus.fetch_pc = pc;
    bus.fetch_inst0 = i0;
    bus.fetch_inst1 = i1;
    bus.issue_count = ic;
    if (!rst_n || fl) begin
      mq.delete();
    end else begin
      rdy = (mq.size() <= DEPTH - 2);
      req = (ic == 2'd3) ? 2 : int'(ic);
      avail = (mq.size() < 2) ? mq.size() : 2;
      np = (req < avail) ? req : avail;
      repeat (np) void'(mq.pop_front());
      if (fv && rdy) begin
        mq.push_back({pc, i0});
        if (i1v) mq.push_back({pc + 32'd4, i1});
      end
    end
    s.av = (mq.size() >= 1);
    s.apc = s.av ? mq[0][63:32] : 32'h0;
    s.ainst = s.av ? mq[0][31:0] : NOP;
    s.bv = (mq.size() >= 2);
    s.bpc = s.bv ? mq[1][63:32] : 32'h0;
    s.binst = s.bv ? mq[1][31:0] : NOP;
    s.occ = mq.size();
    s.rdy = (mq.size() <= DEPTH - 2);
    exp_q.push_back(s);
  endtask

  task automatic settle();
    @(posedge half_clock);
    #2;
  endtask

  // Monitor: after every rising edge, compare the DUT against the oldest prediction.
  initial begin
    snap_t e;
    forever begin
      @(posedge half_clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("slotA_valid", 32'(bus.slotA_valid), 32'(e.av));
        chk("slotA_pc", bus.slotA_pc, e.apc);
        chk("slotA_inst", bus.slotA_inst, e.ainst);
        chk("slotB_valid", 32'(bus.slotB_valid), 32'(e.bv));
        chk("slotB_pc", bus.slotB_pc, e.bpc);
        chk("slotB_inst", bus.slotB_inst, e.binst);
        chk("occupancy", 32'(bus.occupancy), e.occ);
        chk("fetch_ready", 32'(bus.fetch_ready), 32'(e.rdy));
      end
    end
  end

  initial begin
    int cyc;
    logic [31:0] pc;
    bus.flush = 0; bus.fetch_valid = 0; bus.fetch_inst1_valid = 0;
    bus.fetch_pc = 0; bus.fetch_inst0 = 0; bus.fetch_inst1 = 0; bus.issue_count = 0;

    // Reset held for two edges
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("reset_occ", 32'(bus.occupancy), 32'd0);
    chk("reset_ready", 32'(bus.fetch_ready), 32'd1);
    chk("reset_slotA_inst", bus.slotA_inst, NOP);

    // Single push then split issue
    step(1, 0, 1, 1, 32'h100, 32'h00500093, 32'h00308113, 0);
    settle();
    chk("push_slotA_pc", bus.slotA_pc, 32'h100);
    chk("push_slotB_inst", bus.slotB_inst, 32'h00308113);
    chk("push_occ", 32'(bus.occupancy), 32'd2);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    settle();
    chk("split_slotA_pc", bus.slotA_pc, 32'h104);
    chk("split_slotB_valid", 32'(bus.slotB_valid), 32'd0);
    chk("split_occ", 32'(bus.occupancy), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 3);

    // Fill to full; a fifth packet must be ignored
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 1, 1, 32'h400 + 32'(8 * k), 32'hA000 + 32'(k), 32'hB000 + 32'(k), 0);
      settle();
      if (k == 2) begin
        chk("fill3_occ", 32'(bus.occupancy), 32'd6);
        chk("fill3_ready", 32'(bus.fetch_ready), 32'd1);
      end
      if (k >= 3) begin
        chk("fill_full_occ", 32'(bus.occupancy), 32'd8);
        chk("fill_full_ready", 32'(bus.fetch_ready), 32'd0);
      end
    end
    chk("full_slotA_pc", bus.slotA_pc, 32'h400);

    // Flush priority over push and pop at occupancy 5
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 32'h500, 32'h11, 32'h12, 0);
    step(1, 0, 1, 1, 32'h508, 32'h13, 32'h14, 0);
    step(1, 0, 1, 0, 32'h510, 32'h15, 32'h16, 0);
    settle();
    chk("pre_flush_occ", 32'(bus.occupancy), 32'd5);
    step(1, 1, 1, 1, 32'h600, 32'h21, 32'h22, 2);
    settle();
    chk("flush_occ", 32'(bus.occupancy), 32'd0);
    chk("flush_slotA_valid", 32'(bus.slotA_valid), 32'd0);
    step(1, 0, 1, 0, 32'h300, 32'h33, 32'h34, 0);
    settle();
    chk("post_flush_slotA_pc", bus.slotA_pc, 32'h300);

    // Wrap streaming: push 2 and issue 2 every cycle
    step(1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      pc = 32'h200 + 32'(8 * k);
      step(1, 0, 1, 1, pc, 32'hC000 + 32'(k), 32'hD000 + 32'(k), 2);
      settle();
      chk("stream_slotA_pc", bus.slotA_pc, pc);
      chk("stream_occ", 32'(bus.occupancy), 32'd2);
    end

    // Randomized traffic with occasional flush and reset
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
           {$urandom_range(0, 32'h3FFF), 2'b00}, $urandom, $urandom,
           2'($urandom_range(0, 3)));
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);

    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      @(posedge half_clock);
      cyc++;
    end
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
